// File: rtl/ghost_dir_planner_pkg.sv
// Shared encodings for the ghost direction planner: directions, modes, handshake states.
package ghost_dir_planner_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_RIGHT = 2'b11
  } dir_t;

  typedef enum logic [1:0] {
    MODE_SCATTER = 2'b00,
    MODE_CHASE   = 2'b01,
    MODE_FRIGHT  = 2'b10
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_PICK = 2'b10,
    ST_HOLD = 2'b11
  } state_t;

  // Opposite directions differ only in bit 0 (up/down, left/right).
  function automatic logic [1:0] reverse_dir(input logic [1:0] d);
    return d ^ 2'b01;
  endfunction

endpackage

// File: rtl/ghost_dir_planner_if.sv
// Direction handshake between the ghost mover (master) and the planner (slave).
interface ghost_dir_planner_if;
  logic       dir_req;
  logic       dir_ack;
  logic       dir_valid;
  logic [1:0] dir_out;

  modport master (output dir_req, output dir_ack, input dir_valid, input dir_out);
  modport slave  (input dir_req, input dir_ack, output dir_valid, output dir_out);
endinterface

// File: rtl/ghost_dir_planner_lfsr16.sv
// 16-bit Fibonacci LFSR, taps 16/14/13/11, free-running; reusable across ghosts via SEED.
module ghost_dir_planner_lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] q_o
);
  logic [15:0] lfsr_q;
  logic        fb;

  assign fb  = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
  assign q_o = lfsr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= SEED;
    else        lfsr_q <= {lfsr_q[14:0], fb};
  end
endmodule

// File: rtl/ghost_dir_planner.sv
// Ghost direction planner: mode timer, request/ack FSM and candidate-ranked direction choice.
module ghost_dir_planner
  import ghost_dir_planner_pkg::*;
#(
  parameter logic [9:0]  SCATTER_X     = 10'd16,
  parameter logic [8:0]  SCATTER_Y     = 9'd16,
  parameter logic [15:0] SCATTER_TICKS = 16'd420,
  parameter logic [15:0] CHASE_TICKS   = 16'd1200,
  parameter logic [15:0] FRIGHT_TICKS  = 16'd360,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tick_i,
  input  logic                power_pill_i,
  input  logic [9:0]          ghost_x_i,
  input  logic [8:0]          ghost_y_i,
  input  logic [1:0]          ghost_dir_i,
  input  logic                blocked_i,
  input  logic [9:0]          pac_x_i,
  input  logic [8:0]          pac_y_i,
  output logic [1:0]          mode_o,
  ghost_dir_planner_if.slave  dir_if
);

  logic [15:0] lfsr_q;
  logic        lfsr_unused;

  ghost_dir_planner_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .q_o   (lfsr_q)
  );
  assign lfsr_unused = ^lfsr_q[15:2];

  // ---------------- mode timer ----------------
  mode_t       mode_q, mode_d, saved_q, saved_d;
  logic [15:0] timer_q, timer_d, limit;

  always_comb begin
    mode_d  = mode_q;
    saved_d = saved_q;
    timer_d = timer_q;
    case (mode_q)
      MODE_SCATTER: limit = SCATTER_TICKS;
      MODE_CHASE:   limit = CHASE_TICKS;
      default:      limit = FRIGHT_TICKS;
    endcase
    if (power_pill_i) begin
      // Re-eating while frightened must not lose the mode to return to.
      mode_d  = MODE_FRIGHT;
      timer_d = '0;
      if (mode_q != MODE_FRIGHT) saved_d = mode_q;
    end else if (tick_i) begin
      if (timer_q == limit - 16'd1) begin
        timer_d = '0;
        case (mode_q)
          MODE_SCATTER: mode_d = MODE_CHASE;
          MODE_CHASE:   mode_d = MODE_SCATTER;
          default:      mode_d = saved_q;
        endcase
      end else begin
        timer_d = timer_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q  <= MODE_SCATTER;
      saved_q <= MODE_SCATTER;
      timer_q <= '0;
    end else begin
      mode_q  <= mode_d;
      saved_q <= saved_d;
      timer_q <= timer_d;
    end
  end

  assign mode_o = mode_q;

  // ---------------- CALC: target deltas ----------------
  logic [9:0]         tx;
  logic [8:0]         ty;
  logic signed [10:0] dx_calc, dx_q;
  logic signed [9:0]  dy_calc, dy_q;
  logic               fright_q;
  logic [1:0]         rnd_q;
  state_t             state_q;

  assign tx      = (mode_q == MODE_CHASE) ? pac_x_i : SCATTER_X;
  assign ty      = (mode_q == MODE_CHASE) ? pac_y_i : SCATTER_Y;
  assign dx_calc = $signed({1'b0, tx}) - $signed({1'b0, ghost_x_i});
  assign dy_calc = $signed({1'b0, ty}) - $signed({1'b0, ghost_y_i});

  always_ff @(posedge clk) begin
    if (state_q == ST_CALC) begin
      dx_q     <= dx_calc;
      dy_q     <= dy_calc;
      fright_q <= (mode_q == MODE_FRIGHT);
      rnd_q    <= lfsr_q[1:0];
    end
  end

  // ---------------- PICK: ranked candidates ----------------
  logic [10:0] abs_dx, abs_dy;
  logic [1:0]  h_dir, v_dir, p_dir, s_dir, rev_g, pick;
  logic [1:0]  cand [4];
  logic        found;

  always_comb begin
    abs_dx = dx_q[10] ? 11'(-dx_q) : 11'(dx_q);
    abs_dy = {1'b0, (dy_q[9] ? 10'(-dy_q) : 10'(dy_q))};
    h_dir  = dx_q[10] ? DIR_LEFT : DIR_RIGHT;
    v_dir  = dy_q[9]  ? DIR_UP   : DIR_DOWN;
    if (abs_dx >= abs_dy) begin
      p_dir = h_dir;
      s_dir = v_dir;
    end else begin
      p_dir = v_dir;
      s_dir = h_dir;
    end
    if (fright_q) begin
      cand[0] = rnd_q;
      cand[1] = rnd_q + 2'd1;
      cand[2] = rnd_q + 2'd2;
      cand[3] = rnd_q + 2'd3;
    end else begin
      cand[0] = p_dir;
      cand[1] = s_dir;
      cand[2] = reverse_dir(s_dir);
      cand[3] = reverse_dir(p_dir);
    end
    // Reversal is the fallback; with all four directions ranked it is never actually needed.
    rev_g = reverse_dir(ghost_dir_i);
    pick  = rev_g;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (!found && cand[i] != rev_g && !(blocked_i && cand[i] == ghost_dir_i)) begin
        pick  = cand[i];
        found = 1'b1;
      end
    end
  end

  // ---------------- handshake FSM ----------------
  logic       dir_valid_q;
  logic [1:0] dir_out_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      dir_valid_q <= 1'b0;
      dir_out_q   <= DIR_UP;
    end else begin
      case (state_q)
        ST_IDLE: if (dir_if.dir_req) state_q <= ST_CALC;
        ST_CALC: state_q <= ST_PICK;
        ST_PICK: begin
          dir_out_q   <= pick;
          dir_valid_q <= 1'b1;
          state_q     <= ST_HOLD;
        end
        default: if (dir_if.dir_ack) begin
          dir_valid_q <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign dir_if.dir_valid = dir_valid_q;
  assign dir_if.dir_out   = dir_out_q;

endmodule
